// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart_fifo TX port; grant held per message (max MAX_BURST bytes).
// Latency: req -> grant +1, first byte +2; at most 1 byte per 2 cycles; stalls while tx_fifo_full.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           tx_byte,
  output logic                 transmit,
  input  logic                 tx_fifo_full
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SEND   = 1'b1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  // Reset asserts asynchronously, releases two clock edges after RESET_N rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [0:0]         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         burst_q, burst_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               transmit_q, transmit_d;

  logic               win_vld;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;
  logic               issue;
  logic               release_now;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_d     = burst_q;
    last_d      = last_q;
    busy_d      = busy_q;
    ack_d       = '0;
    tx_byte_d   = 8'h00;
    transmit_d  = 1'b0;
    issue       = 1'b0;
    release_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d          = ST_SEND;
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          burst_d          = 8'd0;
          last_d           = 1'b0;
          ptr_d            = IW'((int'(win_idx) + 1) % NUM_REQ);
        end
      end
      default: begin
        issue = req[owner_q] && !tx_fifo_full && !transmit_q;
        // Completion is judged in the cycle the byte is on TX; abort only when idle between bytes.
        release_now = (transmit_q && (last_q || (burst_q == BURST_MAX)))
                    || (!transmit_q && !req[owner_q]);
        if (release_now) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          burst_d = 8'd0;
          last_d  = 1'b0;
        end else if (issue) begin
          transmit_d     = 1'b1;
          tx_byte_d      = req_data[{owner_q, 3'b000} +: 8];
          ack_d[owner_q] = 1'b1;
          burst_d        = burst_q + 8'd1;
          last_d         = req_last[owner_q];
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      burst_q    <= 8'd0;
      tx_byte_q  <= 8'h00;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      transmit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      burst_q    <= burst_d;
      tx_byte_q  <= tx_byte_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      transmit_q <= transmit_d;
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign tx_byte  = tx_byte_q;
  assign transmit = transmit_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single transmit side of uart_fifo between NUM_REQ byte-stream requesters (e.g. echo path, status reporter, debug dumper).
- Grant is locked for a whole message so bytes from different requesters never interleave on TX.
- Drives uart_fifo tx_byte/transmit, throttled by tx_fifo_full.
- Enforces a per-grant burst limit so every requester gets fair access.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
MAX_BURST, 16, maximum bytes sent per grant before forced re-arbitration (1..255).

Ports:
CLK  input  1  system clock, all logic on rising edge.
RESET_N  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  per-requester: byte available on req_data.
req_last  input  NUM_REQ  per-requester: current byte is the last of its message.
req_data  input  8*NUM_REQ  byte of requester i on bits [8*i+7:8*i].
ack  output  NUM_REQ  one-cycle pulse: requester's current byte accepted; present next byte from the following cycle.
grant  output  NUM_REQ  one-hot: current owner; all-zero when idle.
busy  output  1  high while any grant is held.
tx_byte  output  8  to uart_fifo tx_byte.
transmit  output  1  to uart_fifo transmit, one-cycle push pulse.
tx_fifo_full  input  1  from uart_fifo.

Behaviour:
- Reset (async assert, sync release inside block):
  - grant=0, ack=0, busy=0, transmit=0, tx_byte=8'h00.
  - Priority pointer ptr=0; burst count=0; state IDLE.
- All outputs are registered.
- State IDLE:
  - If any req bit is set, pick the first set bit searching from index ptr upward with wrap.
  - Register grant (one-hot) and busy=1; go to SEND. Winner's grant is visible the cycle after req is seen.
  - ptr <= winner+1 mod NUM_REQ, updated on grant.
- State SEND, owner g. A byte is issued in a cycle when all of the following hold:
  - req[g]=1;
  - tx_fifo_full=0;
  - transmit was 0 in the previous cycle.
- On issue:
  - transmit<=1, tx_byte<=req_data[g], ack[g]<=1 (all in the same registered cycle);
  - burst count increments.
- Otherwise transmit=0, tx_byte=8'h00, ack=0.
- Issue rate: at most one byte every 2 cycles. transmit is never high on two consecutive cycles.
- Release from SEND back to IDLE, clearing grant, busy and burst count in the cycle after the releasing event:
  - (a) issued byte had req_last[g]=1;
  - (b) burst count reaches MAX_BURST;
  - (c) req[g] is 0 while owning and no byte is being issued (abort). The partial message is not reported.
- Simultaneous (a)+(b) on the same byte: single release, no extra action.
- IDLE always lasts at least one cycle between grants, so the minimum gap between bytes of different owners is 3 cycles.
- tx_fifo_full high: issue stalls indefinitely, grant held, no ack. Resumes the first eligible cycle after full drops.
- Requesters must hold req_data and req_last stable while req=1 until ack. req_last is sampled only on the issuing cycle.
- req bits of non-owners are ignored during SEND and do not affect ptr.
- Reset mid-message: everything is cleared immediately; the partial message is truncated on TX. No recovery is provided.
- Latency: req rises in IDLE at cycle n -> grant at n+1 -> first transmit/ack at n+2 (if not full).

Test Plan:
1. Single requester 1 sends 3 bytes 0x41,0x42,0x43 with req_last on 0x43:
   - grant=0010 at n+1;
   - transmit pulses at n+2,n+4,n+6 carrying those bytes, ack[1] coincident;
   - grant=0 at n+7.
2. All 4 req high from reset, each sending 1-byte messages: grant order 0,1,2,3,0; ptr wraps; no transmit on consecutive cycles.
3. Requester 2 sends a 20-byte message with MAX_BURST=16 while requester 3 also requests:
   - 16 bytes from 2, then release;
   - grant to 3 for its message;
   - then back to 2 for the remaining 4 bytes.
4. tx_fifo_full held high for 10 cycles mid-message:
   - no transmit/ack during the stall, grant unchanged;
   - next byte issued 1 cycle after full falls.
5. Owner drops req after 2 bytes without req_last: release (busy=0) next cycle; a pending requester is granted the cycle after that.
6. RESET_N pulsed low mid-burst, asynchronous to CLK: all outputs 0 without waiting for a clock edge; after release, arbitration restarts at requester 0.
